dfm_result_arbiter: RTL and testbench
=====================================

Name: dfm_result_arbiter

Overview:
Collects measurement results from NUM_CH frequency-measure channels and serialises them onto the single regfile write port. Each channel gets a one-entry holding slot, so simultaneous results are queued instead of dropped. A round-robin arbiter drains the slots. Writes are held off while the control path reads the regfile. The block sits between the measure_block instances and regfile, where it replaces the one-hot mux.

Parameters:
NUM_CH, 5, number of measurement channels (2..16).
DATA_W, 64, result width in bits.
OVWR_MODE, 0, full-slot policy: 0 = keep held value and drop new result; 1 = overwrite held value with new result.
CH_W, max(1,$clog2(NUM_CH)), derived localparam, width of channel index.

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset
raw_wr_en_i  in  NUM_CH  per-channel result-valid pulse, 1 cycle
raw_wr_data_i  in  NUM_CH*DATA_W  flattened results, channel i at [i*DATA_W +: DATA_W]
wr_stall_i  in  1  regfile busy (reg_rd_en); no grant issued while high
ovf_clr_i  in  NUM_CH  per-channel sticky overflow clear
reg_wr_en_o  out  1  regfile write strobe, 1-cycle pulse
reg_wr_data_o  out  DATA_W  write data, valid with reg_wr_en_o
reg_wr_ch_o  out  CH_W  source channel of current write
pending_o  out  NUM_CH  slot-occupied flags
ovf_o  out  NUM_CH  sticky per-channel overflow flags

Behaviour:
- Reset sys_rst_n is asynchronous, active-low; clock is sys_clk.
- Reset values: reg_wr_en_o=0, reg_wr_data_o=0, reg_wr_ch_o=0, pending_o=0, ovf_o=0, rr_ptr=0, all slot data=0.
- Capture: raw_wr_en_i[i] at edge t loads slot i if it is empty, or if slot i is granted in that same cycle (drain+fill). pending_o[i]=1 from t+1.
- Full slot (pending, not granted) plus new pulse:
  - OVWR_MODE=0: slot data is unchanged.
  - OVWR_MODE=1: slot data is replaced.
  - Either mode: ovf_o[i] is set at t+1.
- Arbitration (combinational, each cycle):
  - If wr_stall_i=0 and any slot is pending, grant the first pending index scanning from rr_ptr upward, wrapping at NUM_CH-1 to 0.
  - On grant g: slot g clears at next edge, unless it is refilled the same cycle. rr_ptr <= (g==NUM_CH-1)?0:g+1.
  - No grant: rr_ptr holds.
- Output register:
  - Edge after a grant: reg_wr_en_o=1, reg_wr_data_o=slot g data, reg_wr_ch_o=g.
  - Otherwise reg_wr_en_o=0; data and ch hold their last values.
- Latency: raw pulse at edge t gives reg_wr_en_o high at edge t+2 minimum (capture, then grant-register).
- Throughput: one write per cycle while unstalled. N simultaneous results drain in N consecutive cycles.
- Stall:
  - wr_stall_i only blocks new grants.
  - An already registered reg_wr_en_o pulse is not retracted. The top-level masks it with ~reg_rd_en and must keep wr_stall_i asserted one cycle before the read window.
  - Slots keep capturing during stall.
- Overflow clear: ovf_clr_i[i] clears ovf_o[i]. A set and a clear in the same cycle resolve to set (set wins).
- Reset mid-operation: all pending results are discarded and no write pulse is emitted after release until new captures arrive.
- Data width is passed through unchanged; no arithmetic on results.

Test Plan:
- Single result: ch2 pulses with 64'h0000_0000_00B7_1B00 at edge 10 -> reg_wr_en_o=1 at edge 12 only, data matches, reg_wr_ch_o=2, pending_o=5'b00000 from edge 12.
- Simultaneous: raw_wr_en_i=5'b11111 with data k=0..4 set to 64'hk -> five consecutive pulses, order ch0,1,2,3,4, each with correct data, no ovf.
- Round-robin fairness: rr_ptr=3 after a ch2 grant, then ch0 and ch4 pending together -> ch4 written first, then ch0.
- Stall: wr_stall_i=1 for 8 cycles with ch1 pending -> no reg_wr_en_o during the stall. Write appears 1 cycle after wr_stall_i falls, with ch1 data.
- Overflow:
  - OVWR_MODE=0, stall high, ch3 pulses A then B -> ovf_o[3]=1, written data=A.
  - Repeat with OVWR_MODE=1 -> written data=B.
  - ovf_clr_i[3] -> ovf_o[3]=0.
- Drain+fill and reset:
  - Ch0 pulses new data in the same cycle its slot is granted -> old data written, pending_o[0] stays 1, new data written next round, no ovf.
  - Assert sys_rst_n low with 3 slots pending -> all outputs 0, no writes after release.

Source files
------------

// File: rtl/dfm_result_arbiter.sv
// -----------------------------------------------------------------------------
// dfm_result_arbiter
//
// Purpose:
//   Serialises results from NUM_CH frequency-measure channels onto the single
//   regfile write port. Each channel owns a one-entry holding slot, so results
//   that arrive together are queued rather than lost. A round-robin arbiter
//   drains the slots at up to one write per cycle. Grants are held off while
//   the control path owns the regfile (wr_stall_i).
//
// Parameters:
//   NUM_CH    - number of measurement channels (2..16)
//   DATA_W    - result width in bits
//   OVWR_MODE - full-slot policy: 0 keeps the held value, 1 overwrites it
//   CH_W      - derived width of a channel index
//
// Ports:
//   sys_clk        in   system clock
//   sys_rst_n      in   asynchronous active-low reset
//   raw_wr_en_i    in   [NUM_CH]         per-channel result-valid pulse
//   raw_wr_data_i  in   [NUM_CH*DATA_W]  results, channel i at [i*DATA_W +: DATA_W]
//   wr_stall_i     in   regfile busy; no new grant while high
//   ovf_clr_i      in   [NUM_CH]         per-channel sticky overflow clear
//   reg_wr_en_o    out  regfile write strobe (1-cycle pulse)
//   reg_wr_data_o  out  [DATA_W]         write data, valid with reg_wr_en_o
//   reg_wr_ch_o    out  [CH_W]           source channel of current write
//   pending_o      out  [NUM_CH]         slot-occupied flags
//   ovf_o          out  [NUM_CH]         sticky per-channel overflow flags
// -----------------------------------------------------------------------------
module dfm_result_arbiter #(
    parameter  int NUM_CH    = 5,
    parameter  int DATA_W    = 64,
    parameter  int OVWR_MODE = 0,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     sys_clk,
    input  logic                     sys_rst_n,
    input  logic [NUM_CH-1:0]        raw_wr_en_i,
    input  logic [NUM_CH*DATA_W-1:0] raw_wr_data_i,
    input  logic                     wr_stall_i,
    input  logic [NUM_CH-1:0]        ovf_clr_i,
    output logic                     reg_wr_en_o,
    output logic [DATA_W-1:0]        reg_wr_data_o,
    output logic [CH_W-1:0]          reg_wr_ch_o,
    output logic [NUM_CH-1:0]        pending_o,
    output logic [NUM_CH-1:0]        ovf_o
);

    // One extra bit so rr_ptr + offset never overflows before the wrap test.
    localparam logic [CH_W:0]   NUM_CH_X = (CH_W + 1)'(NUM_CH);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    logic [DATA_W-1:0] slot_data_q [NUM_CH];
    logic [DATA_W-1:0] slot_data_d [NUM_CH];
    logic [NUM_CH-1:0] pending_q, pending_d;
    logic [NUM_CH-1:0] ovf_q, ovf_d;
    logic [NUM_CH-1:0] ovf_set;
    logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic              wr_en_q, wr_en_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic [CH_W-1:0]   wr_ch_q, wr_ch_d;

    logic              gnt_vld;
    logic [CH_W-1:0]   gnt_idx;
    logic [NUM_CH-1:0] gnt_oh;
    logic [CH_W:0]     cand;

    // -------------------------------------------------------------------------
    // Round-robin arbiter.
    // Offsets are scanned from the farthest back to rr_ptr itself, so the
    // last hit written is the nearest pending slot at or after rr_ptr. This
    // avoids an early loop exit while giving the same priority order.
    // -------------------------------------------------------------------------
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = '0;
        if (!wr_stall_i) begin
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                cand = {1'b0, rr_ptr_q} + (CH_W + 1)'(k);
                if (cand >= NUM_CH_X) begin
                    cand = cand - NUM_CH_X;
                end
                if (pending_q[cand[CH_W-1:0]]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = cand[CH_W-1:0];
                end
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        if (gnt_vld) begin
            gnt_oh[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (gnt_vld) begin
            rr_ptr_d = (gnt_idx == LAST_CH) ? '0 : gnt_idx + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Holding slots.
    // A slot being drained this cycle counts as free, so a new result landing
    // on the grant cycle is captured without loss and without overflow.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d = pending_q;
        ovf_set   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            slot_data_d[i] = slot_data_q[i];
            if (raw_wr_en_i[i]) begin
                if (!pending_q[i] || gnt_oh[i]) begin
                    slot_data_d[i] = raw_wr_data_i[i*DATA_W +: DATA_W];
                    pending_d[i]   = 1'b1;
                end else begin
                    ovf_set[i] = 1'b1;
                    if (OVWR_MODE != 0) begin
                        slot_data_d[i] = raw_wr_data_i[i*DATA_W +: DATA_W];
                    end
                end
            end else if (gnt_oh[i]) begin
                pending_d[i] = 1'b0;
            end
        end
        // A new overflow in the same cycle as a clear must not be lost.
        ovf_d = ovf_set | (ovf_q & ~ovf_clr_i);
    end

    // -------------------------------------------------------------------------
    // Write-port register: strobe pulses for one cycle per grant, data and
    // channel keep their last values between writes.
    // -------------------------------------------------------------------------
    always_comb begin
        wr_en_d   = gnt_vld;
        wr_data_d = wr_data_q;
        wr_ch_d   = wr_ch_q;
        if (gnt_vld) begin
            wr_data_d = slot_data_q[gnt_idx];
            wr_ch_d   = gnt_idx;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending_q <= '0;
            ovf_q     <= '0;
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_data_q <= '0;
            wr_ch_q   <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_data_q[i] <= '0;
            end
        end else begin
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
            wr_ch_q   <= wr_ch_d;
            for (int i = 0; i < NUM_CH; i++) begin
                slot_data_q[i] <= slot_data_d[i];
            end
        end
    end

    assign reg_wr_en_o   = wr_en_q;
    assign reg_wr_data_o = wr_data_q;
    assign reg_wr_ch_o   = wr_ch_q;
    assign pending_o     = pending_q;
    assign ovf_o         = ovf_q;

endmodule

// File: tb/tb_dfm_result_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dfm_result_arbiter
//
// Drives two instances of dfm_result_arbiter (keep-mode and overwrite-mode)
// with identical stimulus and compares both against a queue-of-slots
// reference model every cycle, plus directed scenario expectations.
// -----------------------------------------------------------------------------
module tb_dfm_result_arbiter;

    localparam int NUM_CH = 5;
    localparam int DATA_W = 64;
    localparam int CH_W   = 3;

    logic                     sys_clk = 1'b0;
    logic                     sys_rst_n;
    logic [NUM_CH-1:0]        raw_en;
    logic [NUM_CH*DATA_W-1:0] raw_data;
    logic                     stall;
    logic [NUM_CH-1:0]        clr;

    logic                     wen   [2];
    logic [DATA_W-1:0]        wdata [2];
    logic [CH_W-1:0]          wch   [2];
    logic [NUM_CH-1:0]        pend  [2];
    logic [NUM_CH-1:0]        ovf   [2];

    int n_checks = 0;
    int n_errors = 0;

    always #5 sys_clk = ~sys_clk;

    dfm_result_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OVWR_MODE(0)) u_keep (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .raw_wr_en_i   (raw_en),
        .raw_wr_data_i (raw_data),
        .wr_stall_i    (stall),
        .ovf_clr_i     (clr),
        .reg_wr_en_o   (wen[0]),
        .reg_wr_data_o (wdata[0]),
        .reg_wr_ch_o   (wch[0]),
        .pending_o     (pend[0]),
        .ovf_o         (ovf[0])
    );

    dfm_result_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .OVWR_MODE(1)) u_ovwr (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .raw_wr_en_i   (raw_en),
        .raw_wr_data_i (raw_data),
        .wr_stall_i    (stall),
        .ovf_clr_i     (clr),
        .reg_wr_en_o   (wen[1]),
        .reg_wr_data_o (wdata[1]),
        .reg_wr_ch_o   (wch[1]),
        .pending_o     (pend[1]),
        .ovf_o         (ovf[1])
    );

    // Reference model: index 0 = keep policy, 1 = overwrite policy.
    bit          m_pend  [2][NUM_CH];
    logic [63:0] m_val   [2][NUM_CH];
    bit          m_ovf   [2][NUM_CH];
    int          m_rr    [2];
    bit          m_wen   [2];
    logic [63:0] m_wdata [2];
    int          m_wch   [2];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int m = 0; m < 2; m++) begin
            m_rr[m] = 0;
            m_wen[m] = 1'b0;
            m_wdata[m] = '0;
            m_wch[m] = 0;
            for (int i = 0; i < NUM_CH; i++) begin
                m_pend[m][i] = 1'b0;
                m_val[m][i] = '0;
                m_ovf[m][i] = 1'b0;
            end
        end
    endfunction

    // One clock edge of the specified behaviour, using the inputs in force.
    function automatic void model_step();
        for (int m = 0; m < 2; m++) begin
            int g;
            g = -1;
            if (!stall) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    int c;
                    c = (m_rr[m] + k) % NUM_CH;
                    if (g < 0 && m_pend[m][c]) g = c;
                end
            end
            if (g >= 0) begin
                m_wen[m] = 1'b1;
                m_wdata[m] = m_val[m][g];
                m_wch[m] = g;
                m_rr[m] = (g + 1) % NUM_CH;
            end else begin
                m_wen[m] = 1'b0;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                logic [63:0] d;
                d = raw_data[i*DATA_W +: DATA_W];
                if (clr[i]) m_ovf[m][i] = 1'b0;
                if (raw_en[i]) begin
                    if (!m_pend[m][i] || i == g) begin
                        m_val[m][i] = d;
                        m_pend[m][i] = 1'b1;
                    end else begin
                        m_ovf[m][i] = 1'b1;
                        if (m == 1) m_val[m][i] = d;
                    end
                end else if (i == g) begin
                    m_pend[m][i] = 1'b0;
                end
            end
        end
    endfunction

    task automatic compare_all();
        for (int m = 0; m < 2; m++) begin
            logic [NUM_CH-1:0] ep, eo;
            for (int i = 0; i < NUM_CH; i++) begin
                ep[i] = m_pend[m][i];
                eo[i] = m_ovf[m][i];
            end
            chk($sformatf("m%0d_wen", m),   64'(wen[m]),   64'(m_wen[m]));
            chk($sformatf("m%0d_wdata", m), wdata[m],      m_wdata[m]);
            chk($sformatf("m%0d_wch", m),   64'(wch[m]),   64'(m_wch[m]));
            chk($sformatf("m%0d_pend", m),  64'(pend[m]),  64'(ep));
            chk($sformatf("m%0d_ovf", m),   64'(ovf[m]),   64'(eo));
        end
    endtask

    task automatic set_data(input int ch, input logic [63:0] v);
        raw_data[ch*DATA_W +: DATA_W] = v;
    endtask

    // Called at a falling edge: apply inputs, advance one rising edge, check.
    task automatic cycle(input logic [NUM_CH-1:0] en, input logic st, input logic [NUM_CH-1:0] cl);
        raw_en = en;
        stall  = st;
        clr    = cl;
        @(posedge sys_clk);
        model_step();
        @(negedge sys_clk);
        compare_all();
    endtask

    // Called at a falling edge; returns at a falling edge with reset released.
    task automatic do_reset();
        sys_rst_n = 1'b0;
        raw_en = '0;
        stall  = 1'b0;
        clr    = '0;
        #1;
        model_reset();
        compare_all();
        chk("rst_wen",  64'(wen[0]),  64'd0);
        chk("rst_pend", 64'(pend[0]), 64'd0);
        chk("rst_data", wdata[1],     64'd0);
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        raw_en    = '0;
        raw_data  = '0;
        stall     = 1'b0;
        clr       = '0;
        sys_rst_n = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("init_wen", 64'(wen[0]), 64'd0);
        chk("init_ovf", 64'(ovf[1]), 64'd0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // Single result on ch2: write two edges after the pulse.
        repeat (3) cycle('0, 1'b0, '0);
        set_data(2, 64'h0000_0000_00B7_1B00);
        cycle(5'b00100, 1'b0, '0);
        chk("single_pend_t1", 64'(pend[0]), 64'h04);
        chk("single_wen_t1",  64'(wen[0]),  64'd0);
        cycle('0, 1'b0, '0);
        chk("single_wen",  64'(wen[0]),  64'd1);
        chk("single_data", wdata[0],     64'h0000_0000_00B7_1B00);
        chk("single_ch",   64'(wch[0]),  64'd2);
        chk("single_pend", 64'(pend[0]), 64'd0);
        cycle('0, 1'b0, '0);
        chk("single_once", 64'(wen[0]),  64'd0);

        // Simultaneous results from a fresh reset drain as ch0..ch4.
        do_reset();
        for (int k = 0; k < NUM_CH; k++) set_data(k, 64'(k));
        cycle(5'b11111, 1'b0, '0);
        for (int k = 0; k < NUM_CH; k++) begin
            cycle('0, 1'b0, '0);
            chk($sformatf("sim_wen%0d", k),  64'(wen[0]), 64'd1);
            chk($sformatf("sim_ch%0d", k),   64'(wch[0]), 64'(k));
            chk($sformatf("sim_data%0d", k), wdata[1],    64'(k));
        end
        chk("sim_ovf", 64'(ovf[0] | ovf[1]), 64'd0);

        // Fairness: after a ch2 grant, ch4 beats ch0.
        set_data(2, 64'h22);
        cycle(5'b00100, 1'b0, '0);
        cycle('0, 1'b0, '0);
        chk("rr_ch2", 64'(wch[0]), 64'd2);
        set_data(0, 64'h0A);
        set_data(4, 64'h4A);
        cycle(5'b10001, 1'b0, '0);
        cycle('0, 1'b0, '0);
        chk("rr_first_ch",   64'(wch[0]), 64'd4);
        chk("rr_first_data", wdata[0],    64'h4A);
        cycle('0, 1'b0, '0);
        chk("rr_second_ch",   64'(wch[0]), 64'd0);
        chk("rr_second_data", wdata[0],    64'h0A);

        // Stall for 8 cycles with ch1 pending.
        set_data(1, 64'h1111_2222_3333_4444);
        cycle(5'b00010, 1'b1, '0);
        for (int k = 0; k < 7; k++) begin
            cycle('0, 1'b1, '0);
            chk("stall_wen", 64'(wen[0]), 64'd0);
        end
        cycle('0, 1'b0, '0);
        chk("stall_rel_wen",  64'(wen[0]), 64'd1);
        chk("stall_rel_ch",   64'(wch[0]), 64'd1);
        chk("stall_rel_data", wdata[0],    64'h1111_2222_3333_4444);

        // Overflow on ch3 under stall: keep -> A, overwrite -> B.
        set_data(3, 64'hAAAA);
        cycle(5'b01000, 1'b1, '0);
        set_data(3, 64'hBBBB);
        cycle(5'b01000, 1'b1, '0);
        chk("ovf_keep_set", 64'(ovf[0][3]), 64'd1);
        chk("ovf_ovwr_set", 64'(ovf[1][3]), 64'd1);
        cycle('0, 1'b0, '0);
        chk("ovf_keep_data", wdata[0], 64'hAAAA);
        chk("ovf_ovwr_data", wdata[1], 64'hBBBB);
        cycle('0, 1'b0, 5'b01000);
        chk("ovf_clr", 64'(ovf[0][3]), 64'd0);

        // Set and clear together: set wins.
        set_data(3, 64'hCCCC);
        cycle(5'b01000, 1'b1, '0);
        set_data(3, 64'hDDDD);
        cycle(5'b01000, 1'b1, 5'b01000);
        chk("ovf_set_wins", 64'(ovf[0][3]), 64'd1);
        cycle('0, 1'b0, '0);
        chk("ovf2_keep_data", wdata[0], 64'hCCCC);
        chk("ovf2_ovwr_data", wdata[1], 64'hDDDD);
        cycle('0, 1'b0, 5'b01000);

        // Drain+fill on ch0.
        set_data(0, 64'hD1D1);
        cycle(5'b00001, 1'b0, '0);
        set_data(0, 64'hD2D2);
        cycle(5'b00001, 1'b0, '0);
        chk("df_data1", wdata[0],       64'hD1D1);
        chk("df_ch1",   64'(wch[0]),    64'd0);
        chk("df_pend",  64'(pend[0][0]), 64'd1);
        chk("df_ovf",   64'(ovf[0][0]),  64'd0);
        cycle('0, 1'b0, '0);
        chk("df_wen2",  64'(wen[0]),    64'd1);
        chk("df_data2", wdata[0],       64'hD2D2);

        // Reset with three slots pending: nothing written afterwards.
        cycle(5'b10101, 1'b1, '0);
        chk("rstmid_pend", 64'(pend[0]), 64'h15);
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle('0, 1'b0, '0);
            chk("rstmid_nowr", 64'(wen[0] | wen[1]), 64'd0);
        end

        // Randomized traffic.
        for (int n = 0; n < 3000; n++) begin
            logic [NUM_CH-1:0] en, cl;
            for (int i = 0; i < NUM_CH; i++) begin
                en[i] = ($urandom_range(0, 3) == 0);
                cl[i] = ($urandom_range(0, 15) == 0);
                set_data(i, {$urandom(), $urandom()});
            end
            if (n == 1500) do_reset();
            cycle(en, ($urandom_range(0, 3) == 0), cl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
